// File: rtl/r_id_stage.sv
// r_id_stage: decode stage for R-type instructions. Reads the rs/rt operands
// from a 32x32 register file with a same-cycle write-back bypass, maps
// funct to an ALU opcode, and holds the result in a single output register
// slot for the ALU stage.
//
// Handshake: a transfer on either side happens on a rising clk edge where
// valid && ready are both 1. The producer keeps its payload stable while
// valid=1 and ready=0. inst_ready depends combinationally on out_ready, so
// a full output slot can drain and be refilled on the same edge.
module r_id_stage #(
    parameter int R0_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [4:0]  OP,
    output logic [4:0]  dest,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        wb_zf,
    input  logic        wb_of,
    output logic        zf_q,
    output logic        of_q,
    output logic        ill_inst
);

    logic [31:0] regs [32];

    logic [5:0]  op_field;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [4:0]  unused_shamt;

    logic        legal;
    logic [4:0]  op_dec;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        accept;
    logic        wb_write;

    assign op_field     = inst[31:26];
    assign rs           = inst[25:21];
    assign rt           = inst[20:16];
    assign rd           = inst[15:11];
    assign unused_shamt = inst[10:6];
    assign funct        = inst[5:0];

    assign inst_ready = !out_valid || out_ready;
    assign accept     = inst_valid && inst_ready;

    // Register 0 is hardwired to zero when R0_ZERO is set, so its writes are dropped.
    assign wb_write = wb_en && !((R0_ZERO != 0) && (wb_addr == 5'd0));

    // Decode funct into the ALU opcode; anything else (or op != 0) is illegal.
    always_comb begin
        legal  = 1'b0;
        op_dec = 5'd0;
        if (op_field == 6'd0) begin
            legal = 1'b1;
            case (funct)
                6'b100100: op_dec = 5'b00000; // and
                6'b100101: op_dec = 5'b00001; // or
                6'b100110: op_dec = 5'b00010; // xor
                6'b100111: op_dec = 5'b00011; // nor
                6'b100000: op_dec = 5'b00100; // add
                6'b100010: op_dec = 5'b00101; // sub
                6'b101011: op_dec = 5'b00110; // sltu
                6'b000100: op_dec = 5'b00111; // sllv
                6'b100001: op_dec = 5'b01000; // addu
                default:   legal  = 1'b0;
            endcase
        end
    end

    // Operand read ports with write-back bypass for nonzero addresses.
    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (wb_en && (wb_addr == rs) && (rs != 5'd0)) rs_val = wb_data;
        if (wb_en && (wb_addr == rt) && (rt != 5'd0)) rt_val = wb_data;
        if ((R0_ZERO != 0) && (rs == 5'd0)) rs_val = 32'd0;
        if ((R0_ZERO != 0) && (rt == 5'd0)) rt_val = 32'd0;
    end

    // Register file write port and ZF/OF flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            zf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            if (wb_write) regs[wb_addr] <= wb_data;
            if (wb_en) begin
                zf_q <= wb_zf;
                of_q <= wb_of;
            end
        end
    end

    // Output slot: load on legal accept, drain on transfer out, flag illegal.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            A         <= 32'd0;
            B         <= 32'd0;
            OP        <= 5'd0;
            dest      <= 5'd0;
            ill_inst  <= 1'b0;
        end else begin
            if (accept && legal) begin
                out_valid <= 1'b1;
                A         <= rs_val;
                B         <= rt_val;
                OP        <= op_dec;
                dest      <= rd;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !legal) ill_inst <= 1'b1;
        end
    end

endmodule

// File: tb/tb_r_id_stage.sv
// tb_r_id_stage: directed scenarios plus a random phase for r_id_stage.
// Inputs change on the falling edge; a reference model predicts every output
// and expected ALU payloads wait in exp_q until the DUT transfers them out.
module tb_r_id_stage;

    localparam int W = 74; // {A, B, OP, dest}

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  OP;
    logic [4:0]  dest;
    logic        out_valid;
    logic        out_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_zf;
    logic        wb_of;
    logic        zf_q;
    logic        of_q;
    logic        ill_inst;

    r_id_stage #(.R0_ZERO(1)) dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .A(A), .B(B), .OP(OP), .dest(dest),
        .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_zf(wb_zf), .wb_of(wb_of),
        .zf_q(zf_q), .of_q(of_q), .ill_inst(ill_inst)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state and scoreboard.
    logic [W-1:0] exp_q[$];
    logic [31:0]  m_regs [32];
    logic         m_ov, m_ill, m_zf, m_of;
    logic         last_acc;
    int           n_checks = 0;
    int           n_fail   = 0;

    // Legal funct codes; the opcode is the index into this table.
    logic [5:0] fn_tab [9] = '{6'b100100, 6'b100101, 6'b100110, 6'b100111,
                               6'b100000, 6'b100010, 6'b101011, 6'b000100,
                               6'b100001};

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] fn, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    // One clock cycle: check outputs against the model, advance the model, step.
    task automatic cycle();
        logic         ready_m;
        logic         legal_m;
        logic [4:0]   op_m;
        logic [W-1:0] e;
        #1;
        ready_m  = !m_ov || out_ready;
        last_acc = inst_valid && ready_m;
        if (rst) begin
            m_ov = 1'b0; m_ill = 1'b0; m_zf = 1'b0; m_of = 1'b0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            exp_q.delete();
            last_acc = 1'b0;
        end else begin
            check("inst_ready", W'(inst_ready), W'(ready_m));
            check("out_valid", W'(out_valid), W'(m_ov));
            check("ill_inst", W'(ill_inst), W'(m_ill));
            check("zf_q", W'(zf_q), W'(m_zf));
            check("of_q", W'(of_q), W'(m_of));
            if (m_ov) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_empty", W'(1), W'(0));
                end else begin
                    e = exp_q[0];
                    check("out_data", {A, B, OP, dest}, e);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        m_ov = 1'b0;
                    end
                end
            end
            if (last_acc) begin
                legal_m = 1'b0;
                op_m    = 5'd0;
                if (inst[31:26] == 6'd0)
                    for (int k = 0; k < 9; k++)
                        if (fn_tab[k] == inst[5:0]) begin
                            legal_m = 1'b1;
                            op_m    = 5'(k);
                        end
                if (legal_m) begin
                    exp_q.push_back({m_read(inst[25:21]), m_read(inst[20:16]), op_m, inst[15:11]});
                    m_ov = 1'b1;
                end else begin
                    m_ill = 1'b1;
                end
            end
            if (wb_en) begin
                if (wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
                m_zf = wb_zf;
                m_of = wb_of;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Driver tasks.
    task automatic idle();
        inst_valid = 1'b0;
        wb_en      = 1'b0;
        wb_zf      = 1'b0;
        wb_of      = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cycle();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w);
        logic done;
        done = 1'b0;
        inst = w;
        inst_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            cycle();
            done = last_acc;
        end
        if (!done) check("issue_timeout", W'(0), W'(1));
        inst_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst = 32'd0; out_ready = 1'b1;
        wb_addr = 5'd0; wb_data = 32'd0;
        m_ov = 0; m_ill = 0; m_zf = 0; m_of = 0; last_acc = 0;
        idle();
        @(negedge clk);
        cycle();
        do_reset();

        // Reset values of the output slot.
        check("rst_A", W'(A), W'(0));
        check("rst_B", W'(B), W'(0));
        check("rst_OP", W'(OP), W'(0));
        check("rst_dest", W'(dest), W'(0));
        check("rst_ready", W'(inst_ready), W'(1));

        // Write-back then add.
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);
        issue(mk(6'b100000, 5'd3, 5'd1, 5'd2));
        check("add_valid", W'(out_valid), W'(1));
        check("add_data", {A, B, OP, dest}, {32'd5, 32'd7, 5'b00100, 5'd3});
        cycle();

        // Same-cycle bypass.
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEADBEEF;
        issue(mk(6'b100101, 5'd5, 5'd4, 5'd1));
        wb_en = 1'b0;
        check("bypass_A", W'(A), W'(32'hDEADBEEF));
        check("bypass_B", W'(B), W'(5));
        cycle();

        // Back-pressure: second instruction waits, then loads with no bubble.
        out_ready = 1'b0;
        issue(mk(6'b100010, 5'd6, 5'd1, 5'd2));
        inst = mk(6'b100110, 5'd7, 5'd2, 5'd4);
        inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("bp_ready", W'(inst_ready), W'(0));
        check("bp_hold_OP", W'(OP), W'(5'b00101));
        out_ready = 1'b1;
        cycle();
        check("bp_accept", W'(last_acc), W'(1));
        inst_valid = 1'b0;
        check("bp_no_bubble", W'(out_valid), W'(1));
        check("bp_second", {A, B, OP, dest}, {32'd7, 32'hDEADBEEF, 5'b00010, 5'd7});
        cycle();
        cycle();

        // Illegal: op != 0 with an empty slot.
        issue(32'h8C000000);
        check("ill_op", W'(ill_inst), W'(1));
        check("ill_op_ov", W'(out_valid), W'(0));
        do_reset();
        // Illegal funct while a pending output drains.
        issue(mk(6'b100001, 5'd8, 5'd0, 5'd0));
        issue(mk(6'b111111, 5'd9, 5'd0, 5'd0));
        check("ill_funct", W'(ill_inst), W'(1));
        check("ill_funct_drain", W'(out_valid), W'(0));

        // R0 ignores writes; flags follow write-back.
        wb(5'd0, 32'hFFFFFFFF);
        issue(mk(6'b100100, 5'd10, 5'd0, 5'd0));
        check("r0_A", W'(A), W'(0));
        wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'd1; wb_zf = 1'b1; wb_of = 1'b1;
        cycle();
        idle();
        check("flag_zf", W'(zf_q), W'(1));
        check("flag_of", W'(of_q), W'(1));
        cycle();

        // Reset while an output is pending.
        wb(5'd1, 32'h1234);
        out_ready = 1'b0;
        issue(mk(6'b100000, 5'd12, 5'd1, 5'd11));
        do_reset();
        check("rst_mid_ov", W'(out_valid), W'(0));
        check("rst_mid_ill", W'(ill_inst), W'(0));
        out_ready = 1'b1;
        issue(mk(6'b100000, 5'd13, 5'd1, 5'd11));
        check("rst_mid_regs", {A, B}, W'(0));
        cycle();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if (!inst_valid || last_acc) begin
                inst_valid = ($urandom_range(0, 3) != 0);
                inst = mk(fn_tab[$urandom_range(0, 8)], 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
                if ($urandom_range(0, 9) == 0) inst[31:26] = 6'($urandom_range(1, 63));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en   = ($urandom_range(0, 1) != 0);
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            wb_zf   = 1'($urandom_range(0, 1));
            wb_of   = 1'($urandom_range(0, 1));
            cycle();
        end
        idle();
        out_ready = 1'b1;
        cycle();
        cycle();
        check("final_q_empty", W'(exp_q.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/r_id_stage.md
R_ID_STAGE -- requirements
Module: r_id_stage

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter R0_ZERO, default 1, meaning: when 1, register 0 reads as 0 and ignores writes.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 inst  in  32  R-type instruction word: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0].
REQ-006 inst_valid  in  1  inst presented this cycle.
REQ-007 inst_ready  out  1  stage accepts inst this cycle.
REQ-008 A, B  out  32 each  registered ALU operands from rs and rt.
REQ-009 OP  out  5  registered ALU opcode.
REQ-010 dest  out  5  registered destination register (rd).
REQ-011 out_valid  in→out  1  output; A/B/OP/dest valid for the ALU.
REQ-012 out_ready  in  1  ALU stage consumes the current output.
REQ-013 wb_en, wb_addr[4:0], wb_data[31:0]  in  write-back of ALU result F.
REQ-014 wb_zf, wb_of  in  1 each  ALU ZF/OF accompanying write-back.
REQ-015 zf_q, of_q  out  1 each  flag register.
REQ-016 ill_inst  out  1  sticky illegal-instruction flag.

Function
REQ-017 Register file: 32 x 32-bit, one write port, two combinational read ports (rs, rt).
REQ-018 Write: on a clk edge with wb_en=1, regs[wb_addr] <= wb_data; with R0_ZERO=1, writes to address 0 are discarded.
REQ-019 Bypass: when wb_en=1 and wb_addr equals rs (or rt) and the address is nonzero, the operand captured this cycle SHALL be wb_data, not the old register value.
REQ-020 Flags: on a clk edge with wb_en=1, zf_q <= wb_zf and of_q <= wb_of; otherwise they hold.
REQ-021 Handshake: inst_ready = !out_valid || out_ready, combinational; transfer in occurs when inst_valid && inst_ready.
REQ-022 Transfer out occurs when out_valid && out_ready.
REQ-023 Latency: an accepted legal instruction appears on A/B/OP/dest with out_valid=1 on the next cycle.
REQ-024 Outputs hold while out_valid=1 and out_ready=0; inst is not accepted during that time.
REQ-025 Funct-to-OP decode (op must equal 0):
- 100100→00000 (and); 100101→00001 (or); 100110→00010 (xor); 100111→00011 (nor)
- 100000→00100 (add); 100010→00101 (sub); 101011→00110 (sltu); 000100→00111 (sllv); 100001→01000 (addu)
REQ-026 An accepted instruction with op≠0 or with unlisted funct SHALL be consumed, SHALL set ill_inst=1, and SHALL NOT set out_valid; any pending output SHALL still drain normally.
REQ-027 Drain: when out is transferred and no new legal instruction is accepted in the same cycle, out_valid <= 0.
REQ-028 Simultaneous out-transfer and legal in-transfer: out_valid stays 1 and the outputs load the new instruction, with no bubble.
REQ-029 The block SHALL do no RAW hazard detection beyond the same-cycle bypass; upstream spacing is the user's responsibility.

Reset
REQ-030 With rst=1 at a clk edge: out_valid=0, A=0, B=0, OP=0, dest=0, zf_q=0, of_q=0, ill_inst=0, and all 32 registers=0.
REQ-031 rst has priority over write-back and over instruction acceptance in the same cycle; an in-flight output is discarded.
REQ-032 inst_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-033 Write-back then add:
- wb r1=5, wb r2=7; then inst add rd=3,rs=1,rt=2 → next cycle A=5, B=7, OP=00100, dest=3, out_valid=1.
REQ-034 Bypass:
- wb_en=1, wb_addr=4, wb_data=0xDEADBEEF in the same cycle as inst using rs=4 → A=0xDEADBEEF.
REQ-035 Back-pressure:
- out_ready=0 with two queued instructions → outputs hold and inst_ready=0.
- out_ready=1 → second instruction loads with no bubble.
REQ-036 Illegal instruction:
- inst=0x8C000000 (op≠0) → ill_inst=1, out_valid unchanged.
- funct=111111 → same response.
REQ-037 R0 and flags:
- wb r0=0xFFFFFFFF, then read rs=0 → A=0.
- wb_zf=1, wb_of=1 → zf_q=1 and of_q=1 next cycle.
REQ-038 Reset mid-operation:
- rst asserted while out_valid=1 → next cycle out_valid=0, all registers read 0, ill_inst=0.
